// File: rtl/data_mem_pkg.sv
// Shared types for the Data_RAM arbiter: owner encoding, RV32I size codes and
// the request bundle that travels from the winning port to the RAM.
package data_mem_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        WrEn;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
  } mem_req_t;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// One requester port of the Data_RAM arbiter (CPU LSU or debug/DMA loader).
// Handshake: Req and its payload are held until Gnt; Gnt is combinational and
// completes the access in the same cycle. RdValid/Err pulse one cycle later.
interface data_ram_arbiter_if;
  logic        Req;
  logic        WrEn;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic        Gnt;
  logic        Stall;
  logic        RdValid;
  logic [31:0] RdData;
  logic        Err;

  modport master (
    output Req, WrEn, Funct3, Addr, WrData,
    input  Gnt, Stall, RdValid, RdData, Err
  );

  modport slave (
    input  Req, WrEn, Funct3, Addr, WrData,
    output Gnt, Stall, RdValid, RdData, Err
  );
endinterface

// File: rtl/mem_access_checker.sv
// Combinational legality check of a single Data_RAM access: size code,
// natural alignment, address range and store-with-unsigned-code.
module mem_access_checker
  import data_mem_pkg::*;
#(
  parameter int ADDR_WORDS = 32
) (
  input  mem_req_t iReq,
  output logic     oIllegal
);

  logic wBadF3;
  logic wMisalign;
  logic wOutOfRange;
  logic wStoreUnsigned;

  always_comb begin
    wBadF3         = 1'b0;
    wMisalign      = 1'b0;
    wStoreUnsigned = 1'b0;
    case (iReq.Funct3)
      F3_LB:  ;
      F3_LBU: wStoreUnsigned = iReq.WrEn;
      F3_LH:  wMisalign = iReq.Addr[0];
      F3_LHU: begin
        wMisalign      = iReq.Addr[0];
        wStoreUnsigned = iReq.WrEn;
      end
      F3_LW:  wMisalign = |iReq.Addr[1:0];
      default: wBadF3 = 1'b1;
    endcase
    // Word index compared at full width so huge addresses never alias in range.
    wOutOfRange = ({2'b00, iReq.Addr[31:2]} >= 32'(ADDR_WORDS));
    oIllegal    = wBadF3 | wMisalign | wOutOfRange | wStoreUnsigned;
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-port zero-latency arbiter in front of Data_RAM with an owner FSM, a
// burst cap, access legality filtering and registered per-port responses.
module data_ram_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_WORDS = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  data_ram_arbiter_if.slave   ifA,
  data_ram_arbiter_if.slave   ifB,
  output logic                oMem_WrEn,
  output logic [2:0]          oMem_Funct3,
  output logic [31:0]         oMem_Addr,
  output logic [31:0]         oMem_WrData,
  input  logic [31:0]         iMem_RdData,
  output owner_e              oDbg_Owner
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] BEAT_CAP = BEAT_W'(MAX_BURST - 1);

  owner_e            rOwner;
  owner_e            rLast;
  logic [BEAT_W-1:0] rBeat;

  logic        rA_RdValid;
  logic        rA_Err;
  logic [31:0] rA_RdData;
  logic        rB_RdValid;
  logic        rB_Err;
  logic [31:0] rB_RdData;

  owner_e   wWin;
  logic     wBeatOpen;
  mem_req_t wReq;
  logic     wIllegal;
  logic     wLoadOk;

  // The owner keeps the port while under the cap, or indefinitely if uncontested.
  always_comb begin
    wBeatOpen = (rBeat < BEAT_CAP);
    wWin      = OWN_IDLE;
    if (iRst) begin
      wWin = OWN_IDLE;
    end else if (rOwner == OWN_A && ifA.Req && (wBeatOpen || !ifB.Req)) begin
      wWin = OWN_A;
    end else if (rOwner == OWN_B && ifB.Req && (wBeatOpen || !ifA.Req)) begin
      wWin = OWN_B;
    end else if (ifA.Req && ifB.Req) begin
      wWin = (rLast == OWN_A) ? OWN_B : OWN_A;
    end else if (ifA.Req) begin
      wWin = OWN_A;
    end else if (ifB.Req) begin
      wWin = OWN_B;
    end
  end

  always_comb begin
    wReq = '0;
    case (wWin)
      OWN_A: begin
        wReq.WrEn   = ifA.WrEn;
        wReq.Funct3 = ifA.Funct3;
        wReq.Addr   = ifA.Addr;
        wReq.WrData = ifA.WrData;
      end
      OWN_B: begin
        wReq.WrEn   = ifB.WrEn;
        wReq.Funct3 = ifB.Funct3;
        wReq.Addr   = ifB.Addr;
        wReq.WrData = ifB.WrData;
      end
      default: ;
    endcase
  end

  mem_access_checker #(
    .ADDR_WORDS (ADDR_WORDS)
  ) u_checker (
    .iReq     (wReq),
    .oIllegal (wIllegal)
  );

  // A rejected access still consumes its slot; only the RAM write is blocked.
  assign oMem_WrEn   = wReq.WrEn & ~wIllegal;
  assign oMem_Funct3 = wReq.Funct3;
  assign oMem_Addr   = wReq.Addr;
  assign oMem_WrData = wReq.WrData;

  assign wLoadOk = ~wReq.WrEn & ~wIllegal;

  assign ifA.Gnt   = (wWin == OWN_A);
  assign ifB.Gnt   = (wWin == OWN_B);
  assign ifA.Stall = ifA.Req & ~ifA.Gnt;
  assign ifB.Stall = ifB.Req & ~ifB.Gnt;

  assign ifA.RdValid = rA_RdValid;
  assign ifA.Err     = rA_Err;
  assign ifA.RdData  = rA_RdData;
  assign ifB.RdValid = rB_RdValid;
  assign ifB.Err     = rB_Err;
  assign ifB.RdData  = rB_RdData;

  assign oDbg_Owner = rOwner;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rOwner     <= OWN_IDLE;
      rLast      <= OWN_B;
      rBeat      <= '0;
      rA_RdValid <= 1'b0;
      rA_Err     <= 1'b0;
      rA_RdData  <= '0;
      rB_RdValid <= 1'b0;
      rB_Err     <= 1'b0;
      rB_RdData  <= '0;
    end else begin
      rOwner <= wWin;
      if (wWin != OWN_IDLE) begin
        rLast <= wWin;
      end
      if (wWin == rOwner) begin
        rBeat <= (rBeat == BEAT_CAP) ? BEAT_CAP : rBeat + 1'b1;
      end else begin
        rBeat <= '0;
      end

      rA_RdValid <= (wWin == OWN_A) & wLoadOk;
      rA_Err     <= (wWin == OWN_A) & wIllegal;
      if (wWin == OWN_A && wLoadOk) begin
        rA_RdData <= iMem_RdData;
      end

      rB_RdValid <= (wWin == OWN_B) & wLoadOk;
      rB_Err     <= (wWin == OWN_B) & wIllegal;
      if (wWin == OWN_B && wLoadOk) begin
        rB_RdData <= iMem_RdData;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: Data_RAM stand-in, per-cycle reference model and
// directed scenarios with literal expectations.
module tb_data_ram_arbiter;
  import data_mem_pkg::*;

  localparam int ADDR_WORDS = 32;
  localparam int MAX_BURST  = 4;

  logic        clk;
  logic        rst;
  logic        mem_wren;
  logic [2:0]  mem_f3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  owner_e      dbg_owner;

  int n_pass;
  int n_total;

  data_ram_arbiter_if if_a ();
  data_ram_arbiter_if if_b ();

  data_ram_arbiter #(
    .ADDR_WORDS (ADDR_WORDS),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .iClk        (clk),
    .iRst        (rst),
    .ifA         (if_a),
    .ifB         (if_b),
    .oMem_WrEn   (mem_wren),
    .oMem_Funct3 (mem_f3),
    .oMem_Addr   (mem_addr),
    .oMem_WrData (mem_wdata),
    .iMem_RdData (mem_rdata),
    .oDbg_Owner  (dbg_owner)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (f3[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned size;
    bit          uns;
    uns = 1'b0;
    case (f3)
      3'b000: size = 1;
      3'b001: size = 2;
      3'b010: size = 4;
      3'b100: begin size = 1; uns = 1'b1; end
      3'b101: begin size = 2; uns = 1'b1; end
      default: return 1'b0;
    endcase
    if ((addr % size) != 0) return 1'b0;
    if ((addr / 4) >= ADDR_WORDS) return 1'b0;
    if (wr && uns) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %s expected %s", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- Data_RAM stand-in ----------------
  logic [31:0] ram [0:ADDR_WORDS-1];
  initial for (int i = 0; i < ADDR_WORDS; i++) ram[i] = 32'h1234_8000 + i;

  always_comb mem_rdata = load_ext(ram[mem_addr[6:2]], mem_f3, mem_addr[1:0]);

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[6:2]] <= store_merge(ram[mem_addr[6:2]], mem_f3, mem_addr[1:0], mem_wdata);
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin : compare
    logic [31:0] model_mem [0:ADDR_WORDS-1];
    bit          rq [0:2];
    logic        w_wr [0:2];
    logic [2:0]  w_f3 [0:2];
    logic [31:0] w_ad [0:2];
    logic [31:0] w_wd [0:2];
    bit          ex_valid [0:2];
    bit          ex_err [0:2];
    logic [31:0] ex_data [0:2];
    int          win, prev, run, last;
    bit          legal;
    for (int i = 0; i < ADDR_WORDS; i++) model_mem[i] = 32'h1234_8000 + i;
    prev = 0; run = 0; last = 2;
    for (int p = 0; p < 3; p++) begin ex_valid[p] = 0; ex_err[p] = 0; ex_data[p] = '0; end
    forever begin
      @(negedge clk);
      rq[0] = 1'b0; rq[1] = if_a.Req; rq[2] = if_b.Req;
      w_wr[1] = if_a.WrEn; w_f3[1] = if_a.Funct3; w_ad[1] = if_a.Addr; w_wd[1] = if_a.WrData;
      w_wr[2] = if_b.WrEn; w_f3[2] = if_b.Funct3; w_ad[2] = if_b.Addr; w_wd[2] = if_b.WrData;
      w_wr[0] = 1'b0; w_f3[0] = 3'b000; w_ad[0] = '0; w_wd[0] = '0;

      if (rst) win = 0;
      else if (prev != 0 && rq[prev] && (run < MAX_BURST || !rq[3 - prev])) win = prev;
      else if (rq[1] && rq[2]) win = (last == 1) ? 2 : 1;
      else if (rq[1]) win = 1;
      else if (rq[2]) win = 2;
      else win = 0;
      legal = model_legal(w_wr[win], w_f3[win], w_ad[win]);

      check("cyc_gnt_a", 32'(if_a.Gnt), 32'(win == 1));
      check("cyc_gnt_b", 32'(if_b.Gnt), 32'(win == 2));
      check("cyc_stall_a", 32'(if_a.Stall), 32'(rq[1] && win != 1));
      check("cyc_stall_b", 32'(if_b.Stall), 32'(rq[2] && win != 2));
      check("cyc_mem_wren", 32'(mem_wren), 32'(win != 0 && legal && w_wr[win]));
      check("cyc_mem_f3", 32'(mem_f3), 32'(w_f3[win]));
      check("cyc_mem_addr", mem_addr, w_ad[win]);
      check("cyc_mem_wdata", mem_wdata, w_wd[win]);
      check("cyc_rdvalid_a", 32'(if_a.RdValid), 32'(ex_valid[1]));
      check("cyc_err_a", 32'(if_a.Err), 32'(ex_err[1]));
      check("cyc_rddata_a", if_a.RdData, ex_data[1]);
      check("cyc_rdvalid_b", 32'(if_b.RdValid), 32'(ex_valid[2]));
      check("cyc_err_b", 32'(if_b.Err), 32'(ex_err[2]));
      check("cyc_rddata_b", if_b.RdData, ex_data[2]);
      check("cyc_owner", 32'(dbg_owner), 32'(prev));

      if (rst) begin
        prev = 0; run = 0; last = 2;
        for (int p = 0; p < 3; p++) begin ex_valid[p] = 0; ex_err[p] = 0; ex_data[p] = '0; end
      end else begin
        for (int p = 1; p < 3; p++) begin
          ex_valid[p] = (p == win) && legal && !w_wr[win];
          ex_err[p]   = (p == win) && !legal;
          if (ex_valid[p]) ex_data[p] = load_ext(model_mem[w_ad[win][6:2]], w_f3[win], w_ad[win][1:0]);
        end
        if (win != 0 && legal && w_wr[win])
          model_mem[w_ad[win][6:2]] = store_merge(model_mem[w_ad[win][6:2]], w_f3[win], w_ad[win][1:0], w_wd[win]);
        if (win == 0) begin
          prev = 0; run = 0;
        end else begin
          run  = (win == prev) ? run + 1 : 1;
          prev = win;
          last = win;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_a(input logic req, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
    if_a.Req = req; if_a.WrEn = wr; if_a.Funct3 = f3; if_a.Addr = addr; if_a.WrData = data;
  endtask

  task automatic drive_b(input logic req, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
    if_b.Req = req; if_b.WrEn = wr; if_b.Funct3 = f3; if_b.Addr = addr; if_b.WrData = data;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    string seq;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    drive_a(1'b1, 1'b0, F3_LW, 32'h0, 32'h0);
    drive_b(1'b1, 1'b0, F3_LW, 32'h4, 32'h0);

    // Reset held two edges with both ports requesting
    @(posedge clk);
    #2;
    check("rst_gnt_a", 32'(if_a.Gnt), 32'd0);
    check("rst_gnt_b", 32'(if_b.Gnt), 32'd0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("first_tie_gnt_a", 32'(if_a.Gnt), 32'd1);
    check("first_tie_gnt_b", 32'(if_b.Gnt), 32'd0);
    tick();

    // A alone: LW 0x10
    drive_b(1'b0, 1'b0, F3_LB, 32'h0, 32'h0);
    drive_a(1'b1, 1'b0, F3_LW, 32'h10, 32'h0);
    settle();
    check("a_alone_gnt", 32'(if_a.Gnt), 32'd1);
    tick();
    drive_a(1'b0, 1'b0, F3_LB, 32'h0, 32'h0);
    check("a_lw10_valid", 32'(if_a.RdValid), 32'd1);
    check("a_lw10_data", if_a.RdData, 32'h1234_8004);

    // B out of range, bad size code, store with unsigned code
    drive_b(1'b1, 1'b0, F3_LB, 32'h80, 32'h0);
    settle();
    check("b_oor_gnt", 32'(if_b.Gnt), 32'd1);
    tick();
    check("b_oor_err", 32'(if_b.Err), 32'd1);
    check("b_oor_valid", 32'(if_b.RdValid), 32'd0);
    drive_b(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    tick();
    check("b_badf3_err", 32'(if_b.Err), 32'd1);
    drive_b(1'b1, 1'b1, F3_LBU, 32'h0, 32'h0);
    settle();
    check("b_sbu_wren", 32'(mem_wren), 32'd0);
    tick();
    drive_b(1'b0, 1'b0, F3_LB, 32'h0, 32'h0);
    check("b_sbu_err", 32'(if_b.Err), 32'd1);
    tick();

    // Contention with burst cap
    drive_a(1'b1, 1'b0, F3_LW, 32'h0, 32'h0);
    drive_b(1'b1, 1'b0, F3_LW, 32'h4, 32'h0);
    seq = "";
    for (int i = 0; i < 13; i++) begin
      settle();
      if (if_a.Gnt) seq = {seq, "A"};
      else if (if_b.Gnt) seq = {seq, "B"};
      else seq = {seq, "-"};
      tick();
    end
    check_str("burst_seq", seq, "AAAABBBBAAAAB");
    drive_b(1'b0, 1'b0, F3_LB, 32'h0, 32'h0);
    settle();
    check("b_drop_gnt_a", 32'(if_a.Gnt), 32'd1);
    tick();

    // Misaligned store, then reread word 1
    drive_a(1'b1, 1'b1, F3_LW, 32'h6, 32'hDEAD_BEEF);
    settle();
    check("mis_gnt_a", 32'(if_a.Gnt), 32'd1);
    check("mis_wren", 32'(mem_wren), 32'd0);
    tick();
    drive_a(1'b1, 1'b0, F3_LW, 32'h4, 32'h0);
    check("mis_err_a", 32'(if_a.Err), 32'd1);
    check("mis_valid_a", 32'(if_a.RdValid), 32'd0);
    tick();
    drive_a(1'b1, 1'b0, F3_LW, 32'h7C, 32'h0);
    check("mis_reread", if_a.RdData, 32'h1234_8001);
    tick();
    drive_a(1'b0, 1'b0, F3_LB, 32'h0, 32'h0);
    check("last_word", if_a.RdData, 32'h1234_801F);

    // Byte store then BU / B loads of the same address
    drive_a(1'b1, 1'b1, F3_LB, 32'h21, 32'h0000_00AB);
    settle();
    check("sb_wren", 32'(mem_wren), 32'd1);
    tick();
    drive_a(1'b1, 1'b0, F3_LBU, 32'h21, 32'h0);
    check("sb_no_err", 32'(if_a.Err), 32'd0);
    check("sb_no_valid", 32'(if_a.RdValid), 32'd0);
    tick();
    drive_a(1'b1, 1'b0, F3_LB, 32'h21, 32'h0);
    check("lbu_data", if_a.RdData, 32'h0000_00AB);
    tick();
    drive_a(1'b0, 1'b0, F3_LB, 32'h0, 32'h0);
    check("lb_data", if_a.RdData, 32'hFFFF_FFAB);
    tick();

    // Reset asserted while a store is requested
    drive_a(1'b1, 1'b1, F3_LW, 32'h0, 32'h5555_5555);
    rst = 1'b1;
    settle();
    check("rstmid_gnt_a", 32'(if_a.Gnt), 32'd0);
    check("rstmid_wren", 32'(mem_wren), 32'd0);
    tick();
    rst = 1'b0;
    drive_a(1'b1, 1'b0, F3_LW, 32'h0, 32'h0);
    check("rstmid_valid", 32'(if_a.RdValid), 32'd0);
    check("rstmid_err", 32'(if_a.Err), 32'd0);
    check("rstmid_data", if_a.RdData, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, F3_LB, 32'h0, 32'h0);
    check("rstmid_nowrite", if_a.RdData, 32'h1234_8000);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
